// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues FPU requests and issues them one at a time with a watchdog.
module fpu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int TIMEOUT = 64,
    parameter logic [15:0] NAN_VAL = 16'h7E00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic [1:0]       in_opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic [15:0]      fpu_x,
    output logic [15:0]      fpu_y,
    output logic [1:0]       fpu_opcode,
    output logic             fpu_reset,
    input  logic             fpu_done,
    input  logic [15:0]      fpu_result,
    input  logic [1:0]       fpu_ofuf,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_result,
    output logic [1:0]       resp_ofuf,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_timeout,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, CLEAR, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [15:0] mem_x [DEPTH];
    logic [15:0] mem_y [DEPTH];
    logic [1:0] mem_op [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [WW-1:0] wd;
    logic [TAG_W-1:0] tag_q;
    logic push, pop, wd_expired;

    assign in_ready = count != (AW+1)'(DEPTH);
    assign push = in_valid && in_ready;
    assign pop = state == IDLE && count != '0;
    assign wd_expired = wd == WD_MAX;
    assign fpu_reset = reset || state == CLEAR;
    assign resp_valid = state == RESP;
    assign resp_tag = tag_q;
    assign busy = state != IDLE || count != '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wptr] <= in_x;
            mem_y[wptr] <= in_y;
            mem_op[wptr] <= in_opcode;
            mem_tag[wptr] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(push);
            rptr <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pop ? CLEAR : IDLE;
            CLEAR:   state_n = WAIT;
            WAIT:    state_n = (fpu_done || wd_expired) ? RESP : WAIT;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // Operands latch only on the pop so the FPU sees them stable until the response is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_x <= '0;
            fpu_y <= '0;
            fpu_opcode <= '0;
            tag_q <= '0;
            wd <= '0;
            resp_result <= '0;
            resp_ofuf <= '0;
            resp_timeout <= 1'b0;
        end else begin
            if (pop) begin
                fpu_x <= mem_x[rptr];
                fpu_y <= mem_y[rptr];
                fpu_opcode <= mem_op[rptr];
                tag_q <= mem_tag[rptr];
            end
            if (state == CLEAR) wd <= '0;
            if (state == WAIT) begin
                wd <= wd + WW'(1);
                if (fpu_done) begin
                    resp_result <= fpu_result;
                    resp_ofuf <= fpu_ofuf;
                    resp_timeout <= 1'b0;
                end else if (wd_expired) begin
                    resp_result <= NAN_VAL;
                    resp_ofuf <= 2'b00;
                    resp_timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: table vectors, corner sequences and randomized traffic against a queue-based reference.
module tb_fpu_op_sequencer;
    logic clk, reset, in_valid, in_ready, fpu_reset, fpu_done, resp_valid, resp_ready, resp_timeout, busy;
    logic [15:0] in_x, in_y, fpu_x, fpu_y, fpu_result, resp_result;
    logic [1:0] in_opcode, fpu_opcode, fpu_ofuf, resp_ofuf;
    logic [3:0] in_tag, resp_tag;
    int checks = 0, failures = 0;
    int fpu_lat = 2;
    int mcnt = 0;
    bit done_p;

    typedef struct {logic [15:0] res; logic [1:0] ofuf; logic to; logic [3:0] tag;} exp_t;
    typedef struct {logic [15:0] x, y; logic [1:0] op; logic [3:0] tag; logic [15:0] res; logic [1:0] ofuf; logic to;} vec_t;
    exp_t exp_q[$];
    vec_t tv[4];

    fpu_op_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_opcode(in_opcode), .in_tag(in_tag),
        .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_opcode(fpu_opcode), .fpu_reset(fpu_reset),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_ofuf(fpu_ofuf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_ofuf(resp_ofuf), .resp_tag(resp_tag), .resp_timeout(resp_timeout), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Stand-in FPU: a couple of real values, otherwise a deterministic scramble of the operands.
    function automatic logic [17:0] fn(logic [15:0] x, logic [15:0] y, logic [1:0] op);
        if (op == 2'd0 && x == 16'h3C00 && y == 16'h4000) return {16'h4200, 2'b00};
        if (op == 2'd2 && x == 16'h7800 && y == 16'h7800) return {16'h7C00, 2'b10};
        return {x ^ {y[7:0], y[15:8]} ^ {14'b0, op}, x[5:4]};
    endfunction

    // Operands with a top nibble of F make the model hang, so those commands must time out.
    function automatic exp_t exp_of(logic [15:0] x, logic [15:0] y, logic [1:0] op, logic [3:0] tag);
        exp_t e;
        logic [17:0] r;
        r = fn(x, y, op);
        e.tag = tag;
        e.to = x[15:12] == 4'hF;
        e.res = e.to ? 16'h7E00 : r[17:2];
        e.ofuf = e.to ? 2'b00 : r[1:0];
        return e;
    endfunction

    always @(posedge clk) mcnt <= fpu_reset ? 0 : (mcnt < 1000 ? mcnt + 1 : mcnt);
    assign fpu_done = !fpu_reset && fpu_x[15:12] != 4'hF && mcnt >= fpu_lat;
    assign {fpu_result, fpu_ofuf} = fn(fpu_x, fpu_y, fpu_opcode);

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual_tag=%0h expected=none", resp_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_tag", resp_tag, e.tag);
                chk("sb_result", resp_result, e.res);
                chk("sb_ofuf", resp_ofuf, e.ofuf);
                chk("sb_timeout", resp_timeout, e.to);
            end
        end
    end

    task automatic push(logic [15:0] x, logic [15:0] y, logic [1:0] op, logic [3:0] tag);
        bit ok = 0;
        in_valid = 1; in_x = x; in_y = y; in_opcode = op; in_tag = tag;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (ok) exp_q.push_back(exp_of(x, y, op, tag));
        else begin
            checks++;
            failures++;
            $display("FAIL push_accept actual=stalled expected=accepted tag=%0h", tag);
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = resp_valid;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL resp_wait actual=no_resp expected=resp_valid");
        end
    endtask

    task automatic release_one();
        @(posedge clk); #1 resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && (exp_q.size() != 0 || busy); n++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int n, vcnt;
        tv[0] = '{16'h3C00, 16'h4000, 2'd0, 4'h5, 16'h4200, 2'b00, 1'b0};
        tv[1] = '{16'h7800, 16'h7800, 2'd2, 4'h6, 16'h7C00, 2'b10, 1'b0};
        tv[2] = '{16'hF0A5, 16'h1234, 2'd3, 4'h7, 16'h7E00, 2'b00, 1'b1};
        tv[3] = '{16'h1234, 16'h5678, 2'd1, 4'h9, 16'h6A63, 2'b11, 1'b0};
        reset = 1; in_valid = 0; in_x = 0; in_y = 0; in_opcode = 0; in_tag = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fpu_reset", fpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fpu_x", fpu_x, 0);
        chk("rst_resp", {resp_result, resp_ofuf, resp_tag, resp_timeout}, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("fpu_reset_after_rst", fpu_reset, 0);
        @(posedge clk); #1;

        // Minimum latency: accept on E0, CLEAR after E1, WAIT after E2, RESP after E3.
        fpu_lat = 0;
        in_valid = 1; in_x = 16'h1111; in_y = 16'h2222; in_opcode = 2'd1; in_tag = 4'h3;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 0;
        exp_q.push_back(exp_of(16'h1111, 16'h2222, 2'd1, 4'h3));
        @(negedge clk);
        chk("lat_e0_fpu_reset", fpu_reset, 0);
        chk("lat_e0_busy", busy, 1);
        @(negedge clk);
        chk("lat_e1_fpu_reset", fpu_reset, 1);
        chk("lat_e1_fpu_x", fpu_x, 16'h1111);
        @(negedge clk);
        chk("lat_e2_fpu_reset", fpu_reset, 0);
        chk("lat_e2_resp_valid", resp_valid, 0);
        @(negedge clk);
        chk("lat_e3_resp_valid", resp_valid, 1);
        release_one();

        fpu_lat = 2;
        for (int i = 0; i < 4; i++) begin
            push(tv[i].x, tv[i].y, tv[i].op, tv[i].tag);
            wait_resp(ok);
            if (ok) begin
                chk("vec_result", resp_result, tv[i].res);
                chk("vec_ofuf", resp_ofuf, tv[i].ofuf);
                chk("vec_tag", resp_tag, tv[i].tag);
                chk("vec_timeout", resp_timeout, tv[i].to);
            end
            release_one();
        end

        // Fill: first command parks in RESP, the next four fill the FIFO.
        fpu_lat = 0;
        for (int t = 1; t <= 5; t++) push(16'h0100 * t[15:0], 16'h0042, 2'd2, t[3:0]);
        @(negedge clk);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_resp_valid", resp_valid, 1);
        chk("fill_resp_tag", resp_tag, 1);
        @(posedge clk); #1 resp_ready = 1;
        drain();
        resp_ready = 0;

        // Timeout exactly 64 cycles after WAIT entry, then the next command runs normally.
        resp_ready = 1;
        push(16'hF00D, 16'h0001, 2'd0, 4'hA);
        push(16'h0222, 16'h0333, 2'd3, 4'hB);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = fpu_reset;
        end
        chk("to_clear_seen", ok, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 100);
        chk("to_cycles", n, 65);
        chk("to_result", resp_result, 16'h7E00);
        chk("to_flag", resp_timeout, 1);
        drain();

        // Push lands on the IDLE pop cycle; the second command issues right after the first.
        fpu_lat = 1;
        push(16'h0AAA, 16'h0101, 2'd0, 4'hC);
        push(16'h0BBB, 16'h0202, 2'd1, 4'hD);
        @(negedge clk);
        chk("pp_fpu_reset", fpu_reset, 1);
        chk("pp_fpu_x_a", fpu_x, 16'h0AAA);
        chk("pp_in_ready", in_ready, 1);
        wait_resp(ok);
        @(negedge clk);
        chk("pp_idle_fpu_reset", fpu_reset, 0);
        @(negedge clk);
        chk("pp_b_fpu_reset", fpu_reset, 1);
        chk("pp_fpu_x_b", fpu_x, 16'h0BBB);
        drain();

        done_p = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    fpu_lat = $urandom_range(0, 4);
                    push(16'($urandom), 16'($urandom), 2'($urandom), i[3:0]);
                end
                done_p = 1;
            end
            while (!done_p) begin
                @(posedge clk); #1 resp_ready = $urandom_range(0, 3) != 0;
            end
        join
        resp_ready = 1;
        drain();

        // Reset while a hung command sits in WAIT with two more queued.
        resp_ready = 0;
        push(16'hF111, 16'h0001, 2'd0, 4'h1);
        push(16'h0123, 16'h0001, 2'd0, 4'h2);
        push(16'h0456, 16'h0001, 2'd0, 4'h3);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_fpu_reset", fpu_reset, 1);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_resp_valid", resp_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_fpu_reset", fpu_reset, 0);
        vcnt = 0;
        repeat (100) begin
            @(negedge clk);
            vcnt += (resp_valid || busy) ? 1 : 0;
        end
        chk("post_rst_stale", vcnt, 0);
        @(posedge clk); #1 resp_ready = 1;
        push(16'h0321, 16'h0654, 2'd2, 4'hE);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
